// File: rtl/c17_fault_campaign_seq_if.sv
// Bundle of the sequencer's drive, observe and result-stream signals.
// The master side is the sequencer; the slave side is the netlist/logger environment.
interface c17_fault_campaign_seq_if;
  logic       start;
  logic [5:0] opcode;
  logic [4:0] pat;
  logic       dut_n22;
  logic       dut_n23;
  logic       gold_n22;
  logic       gold_n23;
  logic       res_valid;
  logic       res_ready;
  logic [5:0] res_op;
  logic [5:0] res_hits;
  logic [4:0] res_first;
  logic       busy;
  logic       done;
  logic [5:0] det_count;

  modport master (
    input  start, dut_n22, dut_n23, gold_n22, gold_n23, res_ready,
    output opcode, pat, res_valid, res_op, res_hits, res_first, busy, done, det_count
  );

  modport slave (
    output start, dut_n22, dut_n23, gold_n22, gold_n23, res_ready,
    input  opcode, pat, res_valid, res_op, res_hits, res_first, busy, done, det_count
  );
endinterface

// File: rtl/c17_fault_campaign_seq.sv
// Fault-campaign sequencer for the c17 stuck-at injection netlist.
// Sweeps opcodes OP_FIRST..OP_LAST, applies all 32 patterns to faulty and golden
// instances, and streams one detection record per opcode over a valid/ready port.
// Optional build macro: C17_FSIM_EARLY_EXIT_EN (stop an opcode at its first miss).
module c17_fault_campaign_seq #(
  parameter logic [5:0]  OP_FIRST = 6'd2,
  parameter logic [5:0]  OP_LAST  = 6'd47,
  parameter int unsigned SETTLE   = 1
) (
  input logic                      clk,
  input logic                      rst_n,
  c17_fault_campaign_seq_if.master bus
);

`ifdef C17_FSIM_EARLY_EXIT_EN
  localparam logic EARLY_EXIT = 1'b1;
`else
  localparam logic EARLY_EXIT = 1'b0;
`endif

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRIVE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CMP   = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [2:0] SETTLE_CNT = 3'(SETTLE);

  logic [2:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [5:0] opcode_q, opcode_d;
  logic [4:0] pat_q, pat_d;
  logic [5:0] hits_q, hits_d;
  logic [4:0] first_q, first_d;
  logic       res_valid_q, res_valid_d;
  logic [5:0] res_op_q, res_op_d;
  logic [5:0] res_hits_q, res_hits_d;
  logic [4:0] res_first_q, res_first_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [5:0] det_count_q, det_count_d;

  logic       miss;
  logic [5:0] hits_new;
  logic [4:0] first_new;

  // Per-pattern detection: any output difference between faulty and golden copies.
  // hits cannot exceed 32, so the 6-bit counter never wraps.
  always_comb begin
    miss      = (bus.dut_n22 != bus.gold_n22) | (bus.dut_n23 != bus.gold_n23);
    hits_new  = hits_q + {5'd0, miss};
    first_new = (miss && (hits_q == 6'd0)) ? pat_q : first_q;
  end

  // Campaign FSM next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opcode_d    = opcode_q;
    pat_d       = pat_q;
    hits_d      = hits_q;
    first_d     = first_q;
    res_valid_d = res_valid_q;
    res_op_d    = res_op_q;
    res_hits_d  = res_hits_q;
    res_first_d = res_first_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    det_count_d = det_count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_DRIVE;
          opcode_d    = OP_FIRST;
          pat_d       = 5'd0;
          hits_d      = 6'd0;
          first_d     = 5'd0;
          det_count_d = 6'd0;
          busy_d      = 1'b1;
        end
      end
      S_DRIVE: begin
        cnt_d   = SETTLE_CNT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = S_CMP;
      end
      S_CMP: begin
        hits_d  = hits_new;
        first_d = first_new;
        if ((pat_q == 5'd31) || (EARLY_EXIT && miss)) begin
          // Record is loaded on entry to EMIT so fields are stable for the whole valid window.
          state_d     = S_EMIT;
          res_valid_d = 1'b1;
          res_op_d    = opcode_q;
          res_hits_d  = hits_new;
          res_first_d = first_new;
          if (hits_new != 6'd0) det_count_d = det_count_q + 6'd1;
        end else begin
          pat_d   = pat_q + 5'd1;
          state_d = S_DRIVE;
        end
      end
      S_EMIT: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          hits_d      = 6'd0;
          first_d     = 5'd0;
          pat_d       = 5'd0;
          if (opcode_q == OP_LAST) begin
            state_d  = S_DONE;
            opcode_d = 6'd0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            opcode_d = opcode_q + 6'd1;
            state_d  = S_DRIVE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any campaign and discards the record in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      opcode_q    <= 6'd0;
      pat_q       <= 5'd0;
      hits_q      <= 6'd0;
      first_q     <= 5'd0;
      res_valid_q <= 1'b0;
      res_op_q    <= 6'd0;
      res_hits_q  <= 6'd0;
      res_first_q <= 5'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      det_count_q <= 6'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opcode_q    <= opcode_d;
      pat_q       <= pat_d;
      hits_q      <= hits_d;
      first_q     <= first_d;
      res_valid_q <= res_valid_d;
      res_op_q    <= res_op_d;
      res_hits_q  <= res_hits_d;
      res_first_q <= res_first_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      det_count_q <= det_count_d;
    end
  end

  assign bus.opcode    = opcode_q;
  assign bus.pat       = pat_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_op    = res_op_q;
  assign bus.res_hits  = res_hits_q;
  assign bus.res_first = res_first_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.det_count = det_count_q;

endmodule

// File: tb/tb_c17_fault_campaign_seq.sv
// Bench for c17_fault_campaign_seq: behavioural faulty/golden c17 environment,
// per-opcode reference model, spec-derived detection table, backpressure and reset cases.
module tb_c17_fault_campaign_seq;
  localparam int OPF   = 2;
  localparam int OPL   = 47;
  localparam int N_OPS = OPL - OPF + 1;

  typedef struct {
    logic [5:0] op;
    logic       det;
    logic       chk_first;
    logic [4:0] first;
  } vec_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] hits;
    logic [4:0] first;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  c17_fault_campaign_seq_if ifc ();

  c17_fault_campaign_seq #(
    .OP_FIRST(6'(OPF)),
    .OP_LAST (6'(OPL)),
    .SETTLE  (1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  int   vectors = 0;
  int   miscompares = 0;
  int   ready_mode = 0;
  int   done_seen = 0;
  logic held_v = 1'b0;
  rec_t held_r;
  rec_t got_q[$];
  vec_t tbl[N_OPS];
  int   exp_hits[64];
  int   exp_first[64];

  // Line fault: line index idx stuck at op[0] when op[5:1] selects it.
  function automatic logic flt(input logic v, input int idx, input logic [5:0] op);
    return (int'(op[5:1]) == idx) ? op[0] : v;
  endfunction

  // c17 with injectable stuck-at faults; stems N3/N11/N16 (3, 11, 16) are not wired.
  function automatic logic [1:0] c17_eval(input logic [5:0] op, input logic [4:0] p);
    logic n1, n2, n3, n6, n7, n3a, n3b, n10, n11, n11a, n11b, n16, n16a, n16b, n19, n22, n23;
    n1   = flt(p[4], 1, op);
    n2   = flt(p[3], 2, op);
    n3   = p[2];
    n6   = flt(p[1], 6, op);
    n7   = flt(p[0], 7, op);
    n3a  = flt(n3, 8, op);
    n3b  = flt(n3, 9, op);
    n10  = flt(~(n1 & n3a), 10, op);
    n11  = ~(n3b & n6);
    n11a = flt(n11, 14, op);
    n11b = flt(n11, 15, op);
    n16  = ~(n2 & n11a);
    n19  = flt(~(n11b & n7), 19, op);
    n16a = flt(n16, 20, op);
    n16b = flt(n16, 21, op);
    n22  = flt(~(n10 & n16a), 22, op);
    n23  = flt(~(n16b & n19), 23, op);
    return {n22, n23};
  endfunction

  logic [1:0] dut_o, gold_o;
  assign dut_o        = c17_eval(ifc.opcode, ifc.pat);
  assign gold_o       = c17_eval(6'd0, ifc.pat);
  assign ifc.dut_n22  = dut_o[1];
  assign ifc.dut_n23  = dut_o[0];
  assign ifc.gold_n22 = gold_o[1];
  assign ifc.gold_n23 = gold_o[0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive start/ready at negedge, then observe outputs and the handshake.
  task automatic tick(input logic st);
    rec_t cur;
    @(negedge clk);
    ifc.start = st;
    case (ready_mode)
      0:       ifc.res_ready = 1'b1;
      1:       ifc.res_ready = ($urandom_range(0, 3) != 0);
      default: ifc.res_ready = 1'b0;
    endcase
    if (ifc.done) done_seen++;
    if (ifc.res_valid) begin
      cur.op    = ifc.res_op;
      cur.hits  = ifc.res_hits;
      cur.first = ifc.res_first;
      if (held_v) begin
        chk("hold_op", cur.op, held_r.op);
        chk("hold_hits", cur.hits, held_r.hits);
        chk("hold_first", cur.first, held_r.first);
      end
      if (ifc.res_ready) begin
        got_q.push_back(cur);
        held_v = 1'b0;
      end else begin
        held_v = 1'b1;
        held_r = cur;
      end
    end else begin
      held_v = 1'b0;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_opcode"}, ifc.opcode, 0);
    chk({tag, "_pat"}, ifc.pat, 0);
    chk({tag, "_busy"}, ifc.busy, 0);
    chk({tag, "_done"}, ifc.done, 0);
    chk({tag, "_res_valid"}, ifc.res_valid, 0);
    chk({tag, "_res_op"}, ifc.res_op, 0);
    chk({tag, "_res_hits"}, ifc.res_hits, 0);
    chk({tag, "_res_first"}, ifc.res_first, 0);
    chk({tag, "_det_count"}, ifc.det_count, 0);
  endtask

  task automatic run_campaign(input int rmode, input bit noisy, input string tag);
    int n;
    int det_exp;
    got_q.delete();
    done_seen  = 0;
    ready_mode = rmode;
    tick(1'b1);
    tick(1'b0);
    chk({tag, "_busy_after_start"}, ifc.busy, 1);
    n = 0;
    while (done_seen == 0 && n < 30000) begin
      tick(noisy && ($urandom_range(0, 99) < 4));
      n++;
    end
    if (done_seen == 0) chk({tag, "_timeout"}, 0, 1);
    repeat (5) tick(1'b0);
    chk({tag, "_done_pulses"}, done_seen, 1);
    chk({tag, "_busy_end"}, ifc.busy, 0);
    chk({tag, "_opcode_end"}, ifc.opcode, 0);
    chk({tag, "_records"}, got_q.size(), N_OPS);
    det_exp = 0;
    for (int i = 0; i < N_OPS; i++) begin
      if (tbl[i].det) det_exp++;
      if (i < got_q.size()) begin
        chk({tag, "_rec_op"}, got_q[i].op, tbl[i].op);
        chk({tag, "_rec_hits"}, got_q[i].hits, exp_hits[tbl[i].op]);
        chk({tag, "_rec_first"}, got_q[i].first, exp_first[tbl[i].op]);
        chk({tag, "_rec_det"}, got_q[i].hits != 0, tbl[i].det);
        if (tbl[i].chk_first) chk({tag, "_rec_first_tbl"}, got_q[i].first, tbl[i].first);
      end
    end
    chk({tag, "_det_count"}, ifc.det_count, det_exp);
  endtask

  initial begin
    int undet[18] = '{6, 7, 8, 9, 10, 11, 22, 23, 24, 25, 26, 27, 32, 33, 34, 35, 36, 37};
    int n;
    ifc.start     = 1'b0;
    ifc.res_ready = 1'b0;

    // Detection table: which opcodes must be detected, plus known first patterns.
    for (int i = 0; i < N_OPS; i++) begin
      tbl[i].op        = 6'(OPF + i);
      tbl[i].det       = 1'b1;
      tbl[i].chk_first = 1'b0;
      tbl[i].first     = 5'd0;
      foreach (undet[k]) if (undet[k] == OPF + i) tbl[i].det = 1'b0;
      if (!tbl[i].det) tbl[i].chk_first = 1'b1;
    end
    tbl[0].chk_first = 1'b1;
    tbl[0].first     = 5'h14;

    // Reference model: exhaustive pattern sweep per opcode against the golden copy.
    for (int op = 0; op < 64; op++) begin
      int h;
      int f;
      h = 0;
      f = 0;
      for (int p = 0; p < 32; p++) begin
        if (c17_eval(6'(op), 5'(p)) != c17_eval(6'd0, 5'(p))) begin
          if (h == 0) f = p;
          h++;
        end
      end
`ifdef C17_FSIM_EARLY_EXIT_EN
      if (h > 1) h = 1;
`endif
      exp_hits[op]  = h;
      exp_first[op] = f;
    end

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_reset("por");

    // Backpressure at op 2: record held, no opcode advance, op 3 right after release.
    ready_mode = 2;
    tick(1'b1);
    n = 0;
    while (!ifc.res_valid && n < 2000) begin
      tick(1'b0);
      n++;
    end
    chk("bp_valid_rise", ifc.res_valid, 1);
    chk("bp_res_op", ifc.res_op, 2);
    chk("bp_res_first", ifc.res_first, 5'h14);
    chk("bp_res_hits", ifc.res_hits, exp_hits[2]);
    repeat (10) begin
      tick(1'b0);
      chk("bp_valid_held", ifc.res_valid, 1);
      chk("bp_opcode_held", ifc.opcode, 2);
    end
    ready_mode = 0;
    tick(1'b0);
    ready_mode = 2;
    tick(1'b0);
    chk("bp_valid_drop", ifc.res_valid, 0);
    chk("bp_next_opcode", ifc.opcode, 3);

    // Mid-campaign reset abort, one cycle low.
    ready_mode = 1;
    repeat (150) tick(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset("abort");
    held_v = 1'b0;
    ready_mode = 0;
    repeat (4) tick(1'b0);
    chk("idle_stays_idle", ifc.busy, 0);

    run_campaign(0, 1'b0, "sweep");
    run_campaign(1, 1'b1, "noisy");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
